board_io_arbiter: RTL and testbench
===================================

# board_io_arbiter

Shared board-I/O register bank with a round-robin arbiter, letting the NCORES scr1 cores in the multicore build share the DE1 LEDs, 7-segment displays, switches and keys. It sits between the cores' peripheral request ports and the top-level LEDR/LEDG/HEX0-3/SW/KEY pins. Each core issues single-word transactions. The block grants one core at a time, performs the access, and returns a response.

## Interface
- NCORES, default 4: number of requesting cores, 2..8.
- CLOCK_50  in  1: system clock; all logic on the rising edge.
- rst  in  1: synchronous, active-high reset.
- req  in  NCORES: per-core request; held high until that core samples rvalid.
- we  in  NCORES: per-core write enable; 1 means write, 0 means read.
- addr  in  NCORES*3: per-core word address; core i occupies bits [3i+2:3i].
- wdata  in  NCORES*32: per-core write data; core i occupies bits [32i+31:32i].
- gnt  out  NCORES: one-hot grant, high during the ACCESS state.
- rvalid  out  NCORES: one-hot response strobe, high during the RESP state.
- rdata  out  32: shared read data; valid while any rvalid bit is high, 0 otherwise.
- SW  in  10: raw board switches.
- KEY  in  4: raw board keys; active-low.
- LEDR  out  8: red LEDs.
- LEDG  out  8: green LEDs.
- HEX0, HEX1, HEX2, HEX3  out  7 each: active-low segments; bit0 is segment a … bit6 is segment g.

## Operation
- Register map by word address (unused bits read as 0):
  - 0 LEDR[7:0]: read/write.
  - 1 LEDG[7:0]: read/write.
  - 2 HEXVAL[15:0]: read/write; nibble k drives HEXk.
  - 3 BLANK[3:0]: read/write; bit k=1 forces HEXk to 7'h7F.
  - 4 SW[9:0]: read-only, synchronized.
  - 5 KEY[3:0]: read-only, synchronized raw level.
  - 6 OWNER[2:0]: read-only; index of the last core that wrote any register.
  - 7: reads 0; writes ignored.
  - Writes to read-only addresses are ignored and do not update OWNER.
- The FSM has three states: IDLE, ACCESS and RESP.
  - IDLE: if any req bit is high, the winner is the first set bit at or above rr_ptr, wrapping around. Latch the winner and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: gnt[winner]=1. Sample we, addr and wdata of the winner. A write updates its register at the end of this cycle. A read captures the register into the rdata register. Go to RESP.
  - RESP: rvalid[winner]=1 and rdata is driven. Set rr_ptr = (winner+1) mod NCORES. Go to IDLE.
- req is sampled only in IDLE. If the winner drops req during ACCESS or RESP, the transaction still completes.
- A write's rvalid carries rdata=0.
- SW and KEY each pass through two flip-flop synchronizers. SW syncs reset to 0; KEY syncs reset to 4'hF.
- HEX decode, active-low, gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - BLANK overrides the decode. Segment outputs are registered.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, gnt=0, rvalid=0, rdata=0.
  - LEDR=0, LEDG=0, HEXVAL=0, BLANK=4'hF, so HEX0-3=7'h7F.
  - OWNER=0.
- Latency: req seen in IDLE at edge n, gnt high in cycle n+1, rvalid high in cycle n+2.
- One transaction per 3 cycles. Back-to-back: IDLE is re-entered in cycle n+3.
- A core that samples rvalid=1 must deassert req on that same edge. Otherwise it is treated as a new request.
- A write is visible on LEDR/LEDG at the edge ending ACCESS. HEX pins follow one cycle later because the decode is registered.
- SW/KEY read value lags the pins by 2–3 cycles.
- Simultaneous requests: only one grant; the others wait, with fairness guaranteed by rr_ptr.
- With NCORES requesters all continuously busy, each is served within NCORES transactions (≤3·NCORES cycles).
- Reset asserted in any state: next cycle is IDLE with all reset values. The in-flight transaction is dropped with no rvalid, and a pending write is not committed if reset and the ACCESS edge coincide.

## Test plan
- Reset: assert rst for 2 cycles -> LEDR=0, LEDG=0, HEX0-3=7'h7F, gnt=0, rvalid=0.
- Single write/read: core 1 writes addr 2 data 32'h0000_A180, then reads addr 2 -> gnt[1] one cycle after req. HEX3=08, HEX2=79, HEX1=00, HEX0=40 after BLANK is written 0. Readback rdata=32'h0000A180 and OWNER reads 1.
- Round-robin: cores 0–3 request simultaneously and hold -> grant order 0,1,2,3,0. rvalid arrives exactly 2 cycles after each grant's IDLE sample, with no gnt overlap.
- Read-only and unused addresses: write 32'hFFFF to addr 4 and addr 7 -> SW readback unchanged, OWNER unchanged, addr 7 reads 0.
- Input sync: set SW=10'h2AA and KEY=4'b1011 -> a read of addr 4 issued 3 cycles later returns 32'h2AA, and addr 5 returns 32'hB.
- Reset mid-operation: assert rst during the ACCESS of a write of LEDR=8'h55 -> LEDR stays 0, no rvalid, FSM in IDLE, rr_ptr=0.

Source files
------------

// File: rtl/board_io_arbiter.sv
// Shared board-I/O register bank (LEDs, 7-seg, switches, keys) for the multicore build.
// A round-robin arbiter serves one single-word core transaction every three cycles.
module board_io_arbiter #(
    parameter int NCORES = 4
) (
    input  logic                   CLOCK_50,
    input  logic                   rst,
    input  logic [NCORES-1:0]      req,
    input  logic [NCORES-1:0]      we,
    input  logic [NCORES*3-1:0]    addr,
    input  logic [NCORES*32-1:0]   wdata,
    output logic [NCORES-1:0]      gnt,
    output logic [NCORES-1:0]      rvalid,
    output logic [31:0]            rdata,
    input  logic [9:0]             SW,
    input  logic [3:0]             KEY,
    output logic [7:0]             LEDR,
    output logic [7:0]             LEDG,
    output logic [6:0]             HEX0,
    output logic [6:0]             HEX1,
    output logic [6:0]             HEX2,
    output logic [6:0]             HEX3
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic [2:0]  rr_ptr;
    logic [2:0]  winner;
    logic [2:0]  next_winner;
    logic [2:0]  hi_idx;
    logic [2:0]  lo_idx;
    logic        hi_found;
    logic [15:0] hexval;
    logic [3:0]  blank;
    logic [2:0]  owner;
    logic [9:0]  sw_meta;
    logic [9:0]  sw_sync;
    logic [3:0]  key_meta;
    logic [3:0]  key_sync;
    logic        sel_we;
    logic [2:0]  sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] read_word;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    function automatic logic [NCORES-1:0] onehot(input logic [2:0] idx);
        logic [NCORES-1:0] v;
        for (int i = 0; i < NCORES; i++) begin
            v[i] = (3'(i) == idx);
        end
        return v;
    endfunction

    // Descending scan leaves the lowest requester at/above rr_ptr in hi_idx,
    // and the lowest requester overall in lo_idx for the wrap-around case.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = 3'(i);
                if (i >= int'(rr_ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = 3'(i);
                end
            end
        end
        next_winner = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (3'(i) == winner) begin
                sel_we    = we[i];
                sel_addr  = addr[3*i +: 3];
                sel_wdata = wdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        case (sel_addr)
            3'd0:    read_word = {24'b0, LEDR};
            3'd1:    read_word = {24'b0, LEDG};
            3'd2:    read_word = {16'b0, hexval};
            3'd3:    read_word = {28'b0, blank};
            3'd4:    read_word = {22'b0, sw_sync};
            3'd5:    read_word = {28'b0, key_sync};
            3'd6:    read_word = {29'b0, owner};
            default: read_word = '0;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            winner   <= '0;
            gnt      <= '0;
            rvalid   <= '0;
            rdata    <= '0;
            LEDR     <= '0;
            LEDG     <= '0;
            hexval   <= '0;
            blank    <= 4'hF;
            owner    <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
            key_meta <= 4'hF;
            key_sync <= 4'hF;
            HEX0     <= 7'h7F;
            HEX1     <= 7'h7F;
            HEX2     <= 7'h7F;
            HEX3     <= 7'h7F;
        end else begin
            sw_meta  <= SW;
            sw_sync  <= sw_meta;
            key_meta <= KEY;
            key_sync <= key_meta;
            HEX0     <= blank[0] ? 7'h7F : seg7(hexval[3:0]);
            HEX1     <= blank[1] ? 7'h7F : seg7(hexval[7:4]);
            HEX2     <= blank[2] ? 7'h7F : seg7(hexval[11:8]);
            HEX3     <= blank[3] ? 7'h7F : seg7(hexval[15:12]);

            case (state)
                IDLE: begin
                    if (|req) begin
                        winner <= next_winner;
                        gnt    <= onehot(next_winner);
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    gnt    <= '0;
                    rvalid <= onehot(winner);
                    rdata  <= sel_we ? 32'b0 : read_word;
                    // Only the four writable registers count as a write for OWNER.
                    if (sel_we) begin
                        case (sel_addr)
                            3'd0: begin LEDR   <= sel_wdata[7:0];  owner <= winner; end
                            3'd1: begin LEDG   <= sel_wdata[7:0];  owner <= winner; end
                            3'd2: begin hexval <= sel_wdata[15:0]; owner <= winner; end
                            3'd3: begin blank  <= sel_wdata[3:0];  owner <= winner; end
                            default: ;
                        endcase
                    end
                    state <= RESP;
                end
                RESP: begin
                    rvalid <= '0;
                    rdata  <= '0;
                    rr_ptr <= (winner == 3'(NCORES - 1)) ? 3'd0 : winner + 3'd1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_io_arbiter.sv
// Directed bench for board_io_arbiter: reset values, register map, latency,
// round-robin order, input synchronizers and reset during an in-flight write.
module tb_board_io_arbiter;

    localparam int NC = 4;

    logic              CLOCK_50;
    logic              rst;
    logic [NC-1:0]     req;
    logic [NC-1:0]     we;
    logic [NC*3-1:0]   addr;
    logic [NC*32-1:0]  wdata;
    logic [NC-1:0]     gnt;
    logic [NC-1:0]     rvalid;
    logic [31:0]       rdata;
    logic [9:0]        SW;
    logic [3:0]        KEY;
    logic [7:0]        LEDR;
    logic [7:0]        LEDG;
    logic [6:0]        HEX0;
    logic [6:0]        HEX1;
    logic [6:0]        HEX2;
    logic [6:0]        HEX3;

    int checks = 0;
    int fails  = 0;

    board_io_arbiter #(.NCORES(NC)) dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .SW       (SW),
        .KEY      (KEY),
        .LEDR     (LEDR),
        .LEDG     (LEDG),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    typedef struct {
        int          core;
        logic        wr;
        logic [2:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[17];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Starts at a falling edge with the FSM idle; ends at a falling edge with it idle again.
    task automatic applyStimulus(input int c, input logic w, input logic [2:0] a,
                                 input logic [31:0] d, output logic [31:0] rd);
        logic got;
        got = 1'b0;
        rd  = '0;
        req[c] = 1'b1;
        we[c]  = w;
        addr[3*c +: 3]   = a;
        wdata[32*c +: 32] = d;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge CLOCK_50);
            if (rvalid[c]) begin
                got    = 1'b1;
                rd     = rdata;
                req[c] = 1'b0;
            end
        end
        if (!got) begin
            checks++;
            fails++;
            req[c] = 1'b0;
            $display("[TB] FAIL txn_timeout: core %0d got no rvalid, expected one within 8 cycles", c);
        end
        @(negedge CLOCK_50);
    endtask

    initial begin
        logic [31:0] rd;
        logic [3:0]  eg;
        logic [3:0]  ev;

        vecs[0]  = '{1, 1'b1, 3'd3, 32'h0,      32'h0,      "blank_wr"};
        vecs[1]  = '{1, 1'b0, 3'd2, 32'h0,      32'hA180,   "hexval_rd"};
        vecs[2]  = '{2, 1'b0, 3'd6, 32'h0,      32'h1,      "owner_c1"};
        vecs[3]  = '{0, 1'b1, 3'd0, 32'hA5,     32'h0,      "ledr_wr"};
        vecs[4]  = '{3, 1'b1, 3'd1, 32'h3C,     32'h0,      "ledg_wr"};
        vecs[5]  = '{2, 1'b0, 3'd0, 32'h0,      32'hA5,     "ledr_rd"};
        vecs[6]  = '{2, 1'b0, 3'd1, 32'h0,      32'h3C,     "ledg_rd"};
        vecs[7]  = '{2, 1'b0, 3'd6, 32'h0,      32'h3,      "owner_c3"};
        vecs[8]  = '{0, 1'b1, 3'd4, 32'hFFFF,   32'h0,      "ro_wr"};
        vecs[9]  = '{0, 1'b1, 3'd7, 32'hFFFF,   32'h0,      "unused_wr"};
        vecs[10] = '{1, 1'b0, 3'd6, 32'h0,      32'h3,      "owner_kept"};
        vecs[11] = '{1, 1'b0, 3'd4, 32'h0,      32'h0,      "sw_kept"};
        vecs[12] = '{1, 1'b0, 3'd7, 32'h0,      32'h0,      "unused_rd"};
        vecs[13] = '{1, 1'b0, 3'd3, 32'h0,      32'h0,      "blank_rd"};
        vecs[14] = '{3, 1'b1, 3'd0, 32'h1FF,    32'h0,      "ledr_wide_wr"};
        vecs[15] = '{0, 1'b0, 3'd0, 32'h0,      32'hFF,     "ledr_trunc_rd"};
        vecs[16] = '{0, 1'b0, 3'd5, 32'h0,      32'hF,      "key_idle_rd"};

        rst   = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        SW    = 10'h0;
        KEY   = 4'hF;

        repeat (2) @(negedge CLOCK_50);
        checkOutput("rst_ledr",   32'(LEDR),   32'h0);
        checkOutput("rst_ledg",   32'(LEDG),   32'h0);
        checkOutput("rst_hex0",   32'(HEX0),   32'h7F);
        checkOutput("rst_hex3",   32'(HEX3),   32'h7F);
        checkOutput("rst_gnt",    32'(gnt),    32'h0);
        checkOutput("rst_rvalid", 32'(rvalid), 32'h0);
        checkOutput("rst_rdata",  rdata,       32'h0);
        rst = 1'b0;
        @(negedge CLOCK_50);

        $display("[TB] single write with latency check");
        req[1] = 1'b1;
        we[1]  = 1'b1;
        addr[5:3]    = 3'd2;
        wdata[63:32] = 32'h0000A180;
        @(negedge CLOCK_50);
        checkOutput("lat_gnt",     32'(gnt),    32'h2);
        checkOutput("lat_rv_early", 32'(rvalid), 32'h0);
        @(negedge CLOCK_50);
        checkOutput("lat_rvalid",  32'(rvalid), 32'h2);
        checkOutput("lat_gnt_off", 32'(gnt),    32'h0);
        checkOutput("wr_rdata",    rdata,       32'h0);
        req[1] = 1'b0;
        @(negedge CLOCK_50);
        checkOutput("idle_rdata",  rdata,       32'h0);
        checkOutput("hex_blanked", 32'(HEX0),   32'h7F);

        $display("[TB] table vectors");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].core, vecs[i].wr, vecs[i].a, vecs[i].d, rd);
            checkOutput(vecs[i].name, rd, vecs[i].exp);
        end
        checkOutput("pin_ledr", 32'(LEDR), 32'hFF);
        checkOutput("pin_ledg", 32'(LEDG), 32'h3C);
        checkOutput("pin_hex3", 32'(HEX3), 32'h08);
        checkOutput("pin_hex2", 32'(HEX2), 32'h79);
        checkOutput("pin_hex1", 32'(HEX1), 32'h00);
        checkOutput("pin_hex0", 32'(HEX0), 32'h40);

        $display("[TB] input synchronizers");
        SW  = 10'h2AA;
        KEY = 4'b1011;
        repeat (3) @(negedge CLOCK_50);
        applyStimulus(2, 1'b0, 3'd4, 32'h0, rd);
        checkOutput("sw_sync", rd, 32'h2AA);
        applyStimulus(3, 1'b0, 3'd5, 32'h0, rd);
        checkOutput("key_sync", rd, 32'hB);

        $display("[TB] round-robin with all cores busy");
        rst = 1'b1;
        @(negedge CLOCK_50);
        rst   = 1'b0;
        we    = '0;
        addr  = '0;
        req   = 4'hF;
        for (int k = 1; k <= 15; k++) begin
            @(negedge CLOCK_50);
            eg = (k % 3 == 1) ? 4'(1 << (((k - 1) / 3) % 4)) : 4'h0;
            ev = (k % 3 == 2) ? 4'(1 << (((k - 2) / 3) % 4)) : 4'h0;
            checkOutput($sformatf("rr_gnt_%0d", k),    32'(gnt),    32'(eg));
            checkOutput($sformatf("rr_rvalid_%0d", k), 32'(rvalid), 32'(ev));
        end
        req = '0;
        @(negedge CLOCK_50);

        $display("[TB] reset during a write access");
        rst = 1'b1;
        @(negedge CLOCK_50);
        rst = 1'b0;
        applyStimulus(2, 1'b0, 3'd7, 32'h0, rd);
        checkOutput("pre_abort_rd", rd, 32'h0);
        req[2] = 1'b1;
        we[2]  = 1'b1;
        addr[8:6]    = 3'd0;
        wdata[95:64] = 32'h55;
        @(negedge CLOCK_50);
        checkOutput("abort_gnt", 32'(gnt), 32'h4);
        rst    = 1'b1;
        req[2] = 1'b0;
        @(negedge CLOCK_50);
        checkOutput("abort_ledr",   32'(LEDR),   32'h0);
        checkOutput("abort_gnt0",   32'(gnt),    32'h0);
        checkOutput("abort_rvalid", 32'(rvalid), 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLOCK_50);
            checkOutput($sformatf("abort_no_rv_%0d", k), 32'(rvalid), 32'h0);
        end
        checkOutput("abort_ledr_late", 32'(LEDR), 32'h0);
        we   = '0;
        addr = '0;
        req  = 4'b1001;
        @(negedge CLOCK_50);
        checkOutput("ptr_reset_gnt", 32'(gnt), 32'h1);
        req = 4'b1000;
        @(negedge CLOCK_50);
        checkOutput("ptr_reset_rv", 32'(rvalid), 32'h1);
        req = '0;
        repeat (3) @(negedge CLOCK_50);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
